// File: rtl/core_mc.sv
// core_mc: multi-cycle RV32I-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) on a unified req/ready memory.
// Optional feature macro CORE_MC_PERF_CNT_EN adds 64-bit cycle_cnt / instret_cnt outputs.
module core_mc #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          pc_o,
  output logic                     retire,
  output logic                     halted,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [XLEN-1:0]          dbg_data
`ifdef CORE_MC_PERF_CNT_EN
  ,
  output logic [63:0]              cycle_cnt,
  output logic [63:0]              instret_cnt
`endif
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
    OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_ILL
  } op_e;

  state_e          r_state, w_next;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_alu_out, r_mdr;
  logic [XLEN-1:0] r_regs [NREGS];

  op_e             w_op;
  logic [6:0]      w_opcode, w_f7;
  logic [2:0]      w_f3;
  logic [RW-1:0]   w_rd, w_rs1, w_rs2;
  logic            w_uses_rd, w_uses_rs1, w_uses_rs2;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_alu, w_pc_plus4, w_target;
  logic            w_taken, w_misaligned;
  logic            w_req, w_we, w_retire;
  logic [XLEN-1:0] w_addr, w_wdata;

  assign w_opcode   = r_ir[6:0];
  assign w_f3       = r_ir[14:12];
  assign w_f7       = r_ir[31:25];
  assign w_rd       = r_ir[7 +: RW];
  assign w_rs1      = r_ir[15 +: RW];
  assign w_rs2      = r_ir[20 +: RW];
  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_target   = r_pc + r_imm;

  // Decode is a pure function of IR, which stays stable from FETCH completion until the next fetch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_op       = OP_ILL;
    w_uses_rd  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_imm32    = '0;
    case (w_opcode)
      7'b0110011: begin
        {w_uses_rd, w_uses_rs1, w_uses_rs2} = 3'b111;
        case ({w_f7, w_f3})
          {7'h00, 3'b000}: w_op = OP_ADD;
          {7'h20, 3'b000}: w_op = OP_SUB;
          {7'h00, 3'b111}: w_op = OP_AND;
          {7'h00, 3'b110}: w_op = OP_OR;
          {7'h00, 3'b100}: w_op = OP_XOR;
          {7'h00, 3'b010}: w_op = OP_SLT;
          default:         w_op = OP_ILL;
        endcase
      end
      7'b0010011, 7'b0000011: begin
        {w_uses_rd, w_uses_rs1} = 2'b11;
        w_imm32 = {{20{r_ir[31]}}, r_ir[31:20]};
        if (w_opcode[4] && w_f3 == 3'b000)  w_op = OP_ADDI;
        if (!w_opcode[4] && w_f3 == 3'b010) w_op = OP_LW;
      end
      7'b0100011: begin
        {w_uses_rs1, w_uses_rs2} = 2'b11;
        w_imm32 = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        if (w_f3 == 3'b010) w_op = OP_SW;
      end
      7'b1100011: begin
        {w_uses_rs1, w_uses_rs2} = 2'b11;
        w_imm32 = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        if (w_f3 == 3'b000) w_op = OP_BEQ;
        if (w_f3 == 3'b001) w_op = OP_BNE;
      end
      7'b1101111: begin
        w_uses_rd = 1'b1;
        w_imm32   = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        w_op      = OP_JAL;
      end
      default: ;
    endcase
    // A 16-entry file cannot name registers 16..31; treat such encodings as illegal.
    if (NREGS < 32 && ((w_uses_rd && r_ir[11]) || (w_uses_rs1 && r_ir[19]) || (w_uses_rs2 && r_ir[24])))
      w_op = OP_ILL;
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:                 w_alu = r_a + r_b;
      OP_SUB:                 w_alu = r_a - r_b;
      OP_AND:                 w_alu = r_a & r_b;
      OP_OR:                  w_alu = r_a | r_b;
      OP_XOR:                 w_alu = r_a ^ r_b;
      OP_SLT:                 w_alu = XLEN'($signed(r_a) < $signed(r_b));
      OP_ADDI, OP_LW, OP_SW:  w_alu = r_a + r_imm;
      OP_JAL:                 w_alu = w_pc_plus4;
      default:                w_alu = '0;
    endcase
  end

  assign w_taken      = (w_op == OP_JAL) || (w_op == OP_BEQ && r_a == r_b) || (w_op == OP_BNE && r_a != r_b);
  assign w_misaligned = w_taken && (w_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: w_next = (w_op == OP_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_misaligned) w_next = S_HALT;
        else case (w_op)
          OP_LW, OP_SW:   w_next = S_MEM;
          OP_BEQ, OP_BNE: begin w_next = S_FETCH; w_retire = 1'b1; end
          default:        w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_req  = 1'b1;
        w_addr = r_alu_out;
        if (w_op == OP_SW) begin
          w_we    = 1'b1;
          w_wdata = r_b;
        end
        if (mem_ready) begin
          w_next   = (w_op == OP_SW) ? S_FETCH : S_WB;
          w_retire = (w_op == OP_SW);
        end
      end
      S_WB: begin
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  ;
      default: w_next = S_HALT;
    endcase
  end

  // Reset is gated in directly so an interrupted request drops without waiting for a clock edge.
  assign mem_req   = w_req & ~reset;
  assign mem_we    = w_we & ~reset;
  assign mem_addr  = reset ? '0 : w_addr;
  assign mem_wdata = reset ? '0 : w_wdata;
  assign retire    = w_retire;
  assign halted    = (r_state == S_HALT);
  assign pc_o      = r_pc;
  assign dbg_data  = (dbg_sel == '0) ? '0 : r_regs[dbg_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      // NOTE: the register file is architecturally zero after reset, so it is reset explicitly.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) r_ir <= mem_rdata[31:0];
        S_DECODE: begin
          r_a   <= r_regs[w_rs1];
          r_b   <= r_regs[w_rs2];
          r_imm <= XLEN'($signed(w_imm32));
        end
        S_EXEC: if (!w_misaligned) begin
          r_alu_out <= w_alu;
          if (w_op == OP_BEQ || w_op == OP_BNE) r_pc <= w_taken ? w_target : w_pc_plus4;
          else if (w_op == OP_JAL)              r_pc <= w_target;
        end
        S_MEM: if (mem_ready) begin
          if (w_op == OP_LW) r_mdr <= XLEN'($signed(mem_rdata[31:0]));
          if (w_op == OP_SW) r_pc  <= w_pc_plus4;
        end
        S_WB: begin
          if (w_rd != '0)      r_regs[w_rd] <= (w_op == OP_LW) ? r_mdr : r_alu_out;
          if (w_op != OP_JAL)  r_pc <= w_pc_plus4;
        end
        default: ;
      endcase
    end
  end

`ifdef CORE_MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (r_state != S_HALT) begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (w_retire) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: directed-program bench for core_mc with a wait-state memory model
// (separate wait counts for fetch space below 0x40 and data space at/above 0x40).
module tb_core_mc;

  logic        clk, reset, mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o, dbg_data;
  logic [4:0]  dbg_sel;
`ifdef CORE_MC_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  logic [31:0] mem [64];
  int unsigned d_wait, f_wait, wcnt, need;
  int          n_vec = 0;
  int          n_bad = 0;

  core_mc #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_o(pc_o), .retire(retire), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`ifdef CORE_MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign need      = (mem_addr >= 32'h40) ? d_wait : f_wait;
  assign mem_ready = mem_req && (wcnt >= need);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (mem_req && mem_ready) begin
      wcnt <= 0;
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end else if (mem_req) wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    d_wait  = 0;
    f_wait  = 0;
    dbg_sel = '0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    #1;
  endtask

  task automatic start();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Cycle 1 is the first negedge after reset release / after the previous retire.
  task automatic wait_retire(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (retire === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic run_one(input string tag, input int lat);
    int c;
    wait_retire(c);
    check(tag, c, lat);
    @(posedge clk); #1;
  endtask

  task automatic check_reg(input string tag, input int r, input logic [31:0] exp);
    dbg_sel = 5'(r);
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic mem_instr(input string tag, input int lat, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_we"}, mem_we, we);
        check({tag, "_addr"}, mem_addr, addr);
        if (we) check({tag, "_wdata"}, mem_wdata, wdata);
      end
    end
    check({tag, "_retire"}, retire, 1);
    @(posedge clk); #1;
  endtask

  int lat5 [11] = '{4, 4, 4, 4, 4, 4, 4, 4, 3, 4, 4};
  int reg5 [9]  = '{3, 4, 5, 6, 7, 8, 9, 10, 11};
  logic [31:0] exp5 [9] = '{32'hFFFF_FFF8, 32'h5, 32'hFFFF_FFFD, 32'hFFFF_FFF8,
                            32'h1, 32'h0, 32'd44, 32'h0, 32'h2};

  initial begin
    // Reset state.
    do_reset();
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc_o, 0);

    // ADDI x1,x0,5 retires in cycle 4.
    mem[0] <= 32'h0050_0093;
    start();
    run_one("addi_lat", 4);
    check("addi_pc", pc_o, 32'h4);
    check_reg("addi_x1", 1, 32'h5);

    // BEQ taken over ADDI x3.
    do_reset();
    mem[0] <= 32'h0070_0093;  // addi x1,x0,7
    mem[1] <= 32'h0070_0113;  // addi x2,x0,7
    mem[2] <= 32'h0020_8463;  // beq  x1,x2,+8
    mem[3] <= 32'h0010_0193;  // addi x3,x0,1 (skipped)
    mem[4] <= 32'h0030_0293;  // addi x5,x0,3
    start();
    run_one("beq_i0", 4);
    run_one("beq_i1", 4);
    run_one("beq_lat", 3);
    check("beq_pc", pc_o, 32'h10);
    run_one("beq_i4", 4);
    check_reg("beq_x3", 3, 32'h0);
    check_reg("beq_x5", 5, 32'h3);

    // SW then LW with 2 wait cycles on each data access.
    do_reset();
    d_wait = 2;
    mem[0] <= 32'h1230_0093;  // addi x1,x0,0x123
    mem[1] <= 32'h0400_0113;  // addi x2,x0,0x40
    mem[2] <= 32'h0011_2023;  // sw   x1,0(x2)
    mem[3] <= 32'h0001_2183;  // lw   x3,0(x2)
    start();
    run_one("ls_i0", 4);
    run_one("ls_i1", 4);
    mem_instr("sw", 6, 1'b1, 32'h40, 32'h123);
    check("sw_mem", mem[16], 32'h123);
    mem_instr("lw", 7, 1'b0, 32'h40, 32'h0);
    check_reg("lw_x3", 3, 32'h123);

    // Writes to x0 are discarded.
    do_reset();
    mem[0] <= 32'h0010_0213;  // addi x4,x0,1
    mem[1] <= 32'h0090_0013;  // addi x0,x0,9
    mem[2] <= 32'h0000_0233;  // add  x4,x0,x0
    start();
    run_one("x0_i0", 4);
    run_one("x0_i1", 4);
    run_one("x0_i2", 4);
    check_reg("x0_dbg", 0, 32'h0);
    check_reg("x0_x4", 4, 32'h0);

    // ALU mix, BNE taken, JAL link.
    do_reset();
    mem[0]  <= 32'hFFD0_0093;  // addi x1,x0,-3
    mem[1]  <= 32'h0050_0113;  // addi x2,x0,5
    mem[2]  <= 32'h4020_81B3;  // sub  x3,x1,x2
    mem[3]  <= 32'h0020_F233;  // and  x4,x1,x2
    mem[4]  <= 32'h0020_E2B3;  // or   x5,x1,x2
    mem[5]  <= 32'h0020_C333;  // xor  x6,x1,x2
    mem[6]  <= 32'h0020_A3B3;  // slt  x7,x1,x2
    mem[7]  <= 32'h0011_2433;  // slt  x8,x2,x1
    mem[8]  <= 32'h0020_9463;  // bne  x1,x2,+8
    mem[9]  <= 32'h0010_0513;  // addi x10,x0,1 (skipped)
    mem[10] <= 32'h0080_04EF;  // jal  x9,+8
    mem[11] <= 32'h0010_0513;  // addi x10,x0,1 (skipped)
    mem[12] <= 32'h0020_0593;  // addi x11,x0,2
    start();
    for (int i = 0; i < 11; i++) run_one($sformatf("mix_lat%0d", i), lat5[i]);
    for (int i = 0; i < 9; i++) check_reg($sformatf("mix_x%0d", reg5[i]), reg5[i], exp5[i]);
    repeat (3) @(negedge clk);
    check("mix_halted", halted, 1);
    check("mix_pc", pc_o, 32'd52);

    // Illegal opcode halts two cycles after fetch; reset recovers.
    do_reset();
    mem[0] <= 32'h0000_007F;
    start();
    @(negedge clk);
    @(negedge clk);
    check("ill_halt_c2", halted, 0);
    @(negedge clk);
    check("ill_halt_c3", halted, 1);
    check("ill_req", mem_req, 0);
    repeat (3) @(negedge clk);
    check("ill_req_late", mem_req, 0);
    check("ill_pc", pc_o, 32'h0);
    reset = 1'b1;
    #1;
    check("ill_rst_halted", halted, 0);
    start();
    @(negedge clk);
    check("ill_refetch_req", mem_req, 1);
    check("ill_refetch_addr", mem_addr, 32'h0);

    // Misaligned JAL target halts without retiring or updating PC/rd.
    do_reset();
    mem[0] <= 32'h0060_00EF;  // jal x1,+6
    start();
    repeat (3) @(negedge clk);
    check("mis_retire", retire, 0);
    @(negedge clk);
    check("mis_halted", halted, 1);
    check("mis_pc", pc_o, 32'h0);
    check_reg("mis_x1", 1, 32'h0);

    // Reset while FETCH waits for mem_ready.
    do_reset();
    mem[0] <= 32'h0050_0093;
    start();
    run_one("rw_i0", 4);
    f_wait = 100;
    @(negedge clk);
    check("rw_req_wait", mem_req, 1);
    check_reg("rw_x1_pre", 1, 32'h5);
    #2;
    reset = 1'b1;
    #1;
    check("rw_req_drop", mem_req, 0);
    check("rw_addr_drop", mem_addr, 32'h0);
    check("rw_pc", pc_o, 32'h0);
    check_reg("rw_x1", 1, 32'h0);
`ifdef CORE_MC_PERF_CNT_EN
    check("rw_cycle_cnt", cycle_cnt, 64'h0);
    check("rw_instret_cnt", instret_cnt, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
